// File: rtl/phy_mdio_ifc_if.sv
// MDIO pad-side bundle for phy_mdio_ifc: serial data, tri-state enable
// and the sequence-complete flag. The sequencer drives it through the
// master modport. The pad buffer or the MAC top reads it through slave.
interface phy_mdio_ifc_if;
  logic mdio_o;
  logic mdio_t;
  logic done;

  modport master (output mdio_o, output mdio_t, output done);
  modport slave  (input  mdio_o, input  mdio_t, input  done);
endinterface

// File: rtl/phy_mdio_ifc.sv
// phy_mdio_ifc: autonomous MDIO sequencer that configures an Ethernet PHY
// after reset. It sends three Clause-22 write frames. Each frame is
// preceded by an idle gap. The block then parks in DONE with the line
// released. clk is the MDC-rate bit clock.
//
// Each frame is 32 preamble ones, then the 32-bit payload sent LSB
// first, then one release cycle.
//
// Optional build macro MDIO_RESTART_EN adds a `restart` input. Pulsing
// it while in DONE replays the whole sequence. In the default build
// DONE is terminal until reset.
module phy_mdio_ifc #(
  parameter int          GAP_CYCLES = 64,
  parameter logic [31:0] CMD1       = 32'h008C410A,
  parameter logic [31:0] CMD2       = 32'h0000650A,
  parameter logic [31:0] CMD3       = 32'h00CC410A
) (
  input  logic               clk,
  input  logic               reset,
`ifdef MDIO_RESTART_EN
  input  logic               restart,
`endif
  phy_mdio_ifc_if.master     mdio,
  output logic [2:0]         state,
  output logic [6:0]         gap_cnt,
  output logic [6:0]         bit_cnt
);

  // State encoding is fixed because the debug port exposes it.
  localparam logic [2:0] GAP1     = 3'd0;
  localparam logic [2:0] COMMAND1 = 3'd1;
  localparam logic [2:0] GAP2     = 3'd2;
  localparam logic [2:0] COMMAND2 = 3'd3;
  localparam logic [2:0] GAP3     = 3'd4;
  localparam logic [2:0] COMMAND3 = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic [6:0] GAP_LAST      = 7'(GAP_CYCLES);
  localparam logic [6:0] PREAMBLE_BITS = 7'd32;
  localparam logic [6:0] FRAME_BITS    = 7'd64;

  logic [31:0] cmd_word;

  // Pick the payload for the command state currently being sent.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cmd_word = CMD1;
    case (state)
      COMMAND2: cmd_word = CMD2;
      COMMAND3: cmd_word = CMD3;
      default:  cmd_word = CMD1;
    endcase
  end

  // done is decoded straight from the registered state.
  assign mdio.done = (state == DONE);

  // Sequencer: gap timing, frame serialisation and registered pad outputs.
  // NOTE: clocked state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= GAP1;
      gap_cnt     <= '0;
      bit_cnt     <= '0;
      mdio.mdio_o <= 1'b0;
      mdio.mdio_t <= 1'b1;
    end else begin
      case (state)
        GAP1, GAP2, GAP3: begin
          mdio.mdio_o <= 1'b0;
          mdio.mdio_t <= 1'b1;
          if (gap_cnt < GAP_LAST) begin
            gap_cnt <= gap_cnt + 7'd1;
          end else begin
            gap_cnt <= '0;
            bit_cnt <= '0;
            state   <= state + 3'd1;
          end
        end

        COMMAND1, COMMAND2, COMMAND3: begin
          if (bit_cnt < PREAMBLE_BITS) begin
            mdio.mdio_t <= 1'b0;
            mdio.mdio_o <= 1'b1;
            bit_cnt     <= bit_cnt + 7'd1;
          end else if (bit_cnt < FRAME_BITS) begin
            // bit_cnt is in 32..63 here, so its low five bits equal b-32.
            mdio.mdio_t <= 1'b0;
            mdio.mdio_o <= cmd_word[bit_cnt[4:0]];
            bit_cnt     <= bit_cnt + 7'd1;
          end else begin
            mdio.mdio_t <= 1'b1;
            mdio.mdio_o <= 1'b0;
            bit_cnt     <= '0;
            state       <= (state == COMMAND3) ? DONE : state + 3'd1;
          end
        end

        DONE: begin
          mdio.mdio_t <= 1'b1;
          mdio.mdio_o <= 1'b0;
          gap_cnt     <= '0;
          bit_cnt     <= '0;
`ifdef MDIO_RESTART_EN
          if (restart) begin
            state <= GAP1;
          end
`endif
        end

        default: begin
          // Encoding 7 is unreachable. Recover into a clean sequence.
          state       <= GAP1;
          gap_cnt     <= '0;
          bit_cnt     <= '0;
          mdio.mdio_t <= 1'b1;
          mdio.mdio_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_mdio_ifc.sv
// Directed testbench for phy_mdio_ifc.
// Each task drives one scenario and checks the outputs inline.
// Outputs are sampled #1 after each rising edge.
// edge_n counts rising edges since reset was released.
module tb_phy_mdio_ifc;

  logic       clk;
  logic       reset;
`ifdef MDIO_RESTART_EN
  logic       restart;
`endif
  logic [2:0] state;
  logic [6:0] gap_cnt;
  logic [6:0] bit_cnt;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  localparam logic [31:0] EXP_CMD1 = 32'h008C410A;
  localparam logic [31:0] EXP_CMD2 = 32'h0000650A;
  localparam logic [31:0] EXP_CMD3 = 32'h00CC410A;

  phy_mdio_ifc_if mdio_bus ();

  phy_mdio_ifc dut (
    .clk     (clk),
    .reset   (reset),
`ifdef MDIO_RESTART_EN
    .restart (restart),
`endif
    .mdio    (mdio_bus),
    .state   (state),
    .gap_cnt (gap_cnt),
    .bit_cnt (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Hold reset for two edges, check the reset state, then release.
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++;
    if (gap_cnt !== 7'd0) begin failures++; $display("FAIL reset_gap_cnt: got %0d expected 0", gap_cnt); end
    checks++;
    if (bit_cnt !== 7'd0) begin failures++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
    checks++;
    if (mdio_bus.mdio_o !== 1'b0) begin failures++; $display("FAIL reset_mdio_o: got %b expected 0", mdio_bus.mdio_o); end
    checks++;
    if (mdio_bus.mdio_t !== 1'b1) begin failures++; $display("FAIL reset_mdio_t: got %b expected 1", mdio_bus.mdio_t); end
    checks++;
    if (mdio_bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", mdio_bus.done); end
    reset  = 1'b0;
    edge_n = 0;
  endtask

  // Edges 1..64 count the gap up. Edge 65 enters COMMAND1.
  task automatic test_gap1();
    for (int i = 1; i <= 64; i++) begin
      tick();
      checks++;
      if (gap_cnt !== 7'(i)) begin failures++; $display("FAIL gap1_cnt: edge %0d got %0d expected %0d", edge_n, gap_cnt, i); end
      checks++;
      if (state !== 3'd0) begin failures++; $display("FAIL gap1_state: edge %0d got %0d expected 0", edge_n, state); end
      checks++;
      if (mdio_bus.mdio_t !== 1'b1) begin failures++; $display("FAIL gap1_mdio_t: edge %0d got %b expected 1", edge_n, mdio_bus.mdio_t); end
    end
    tick();
    checks++;
    if (state !== 3'd1) begin failures++; $display("FAIL gap1_exit_state: got %0d expected 1", state); end
    checks++;
    if (gap_cnt !== 7'd0) begin failures++; $display("FAIL gap1_exit_cnt: got %0d expected 0", gap_cnt); end
    checks++;
    if (mdio_bus.mdio_t !== 1'b1) begin failures++; $display("FAIL gap1_exit_mdio_t: got %b expected 1", mdio_bus.mdio_t); end
  endtask

  // Edges 66..97 drive 32 preamble ones.
  task automatic test_preamble();
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if (mdio_bus.mdio_t !== 1'b0 || mdio_bus.mdio_o !== 1'b1) begin
        failures++;
        $display("FAIL preamble: edge %0d got t=%b o=%b expected t=0 o=1", edge_n, mdio_bus.mdio_t, mdio_bus.mdio_o);
      end
    end
    checks++;
    if (bit_cnt !== 7'd32) begin failures++; $display("FAIL preamble_bit_cnt: got %0d expected 32", bit_cnt); end
  endtask

  // Edges 98..129 carry the payload. Edge 130 releases the line and enters GAP2.
  task automatic test_frame1();
    logic [31:0] cap;
    cap = '0;
    for (int i = 0; i < 32; i++) begin
      tick();
      cap[i] = mdio_bus.mdio_o;
      checks++;
      if (mdio_bus.mdio_t !== 1'b0) begin failures++; $display("FAIL frame1_mdio_t: edge %0d got %b expected 0", edge_n, mdio_bus.mdio_t); end
    end
    checks++;
    if (cap !== EXP_CMD1) begin failures++; $display("FAIL frame1_payload: got %08h expected %08h", cap, EXP_CMD1); end
    tick();
    checks++;
    if (mdio_bus.mdio_t !== 1'b1 || mdio_bus.mdio_o !== 1'b0) begin
      failures++;
      $display("FAIL frame1_release: got t=%b o=%b expected t=1 o=0", mdio_bus.mdio_t, mdio_bus.mdio_o);
    end
    checks++;
    if (state !== 3'd2) begin failures++; $display("FAIL frame1_next_state: got %0d expected 2", state); end
  endtask

  // Run edges 131..400. Capture frames 2 and 3 and check DONE after edge 390.
  task automatic test_full_sequence();
    logic [31:0] cap2;
    logic [31:0] cap3;
    cap2 = '0;
    cap3 = '0;
    while (edge_n < 400) begin
      tick();
      if (edge_n >= 228 && edge_n <= 259) cap2[edge_n - 228] = mdio_bus.mdio_o;
      if (edge_n >= 358 && edge_n <= 389) cap3[edge_n - 358] = mdio_bus.mdio_o;
      checks++;
      if (mdio_bus.mdio_t === 1'b1 && mdio_bus.mdio_o !== 1'b0) begin
        failures++;
        $display("FAIL released_low: edge %0d got o=%b expected 0", edge_n, mdio_bus.mdio_o);
      end
      if (edge_n == 195 || edge_n == 325) begin
        checks++;
        if (state !== ((edge_n == 195) ? 3'd3 : 3'd5)) begin failures++; $display("FAIL cmd_entry: edge %0d got state %0d", edge_n, state); end
      end
      if (edge_n == 389) begin
        checks++;
        if (mdio_bus.done !== 1'b0) begin failures++; $display("FAIL done_early: got %b expected 0", mdio_bus.done); end
      end
      if (edge_n >= 390) begin
        checks++;
        if (state !== 3'd6 || mdio_bus.done !== 1'b1 || mdio_bus.mdio_t !== 1'b1) begin
          failures++;
          $display("FAIL done_hold: edge %0d got state=%0d done=%b t=%b expected 6 1 1", edge_n, state, mdio_bus.done, mdio_bus.mdio_t);
        end
        checks++;
        if (gap_cnt !== 7'd0 || bit_cnt !== 7'd0) begin
          failures++;
          $display("FAIL done_counters: got gap=%0d bit=%0d expected 0 0", gap_cnt, bit_cnt);
        end
      end
    end
    checks++;
    if (cap2 !== EXP_CMD2) begin failures++; $display("FAIL frame2_payload: got %08h expected %08h", cap2, EXP_CMD2); end
    checks++;
    if (cap3 !== EXP_CMD3) begin failures++; $display("FAIL frame3_payload: got %08h expected %08h", cap3, EXP_CMD3); end
  endtask

`ifdef MDIO_RESTART_EN
  // A restart pulse in DONE returns the sequencer to GAP1 with clear counters.
  task automatic test_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if (state !== 3'd0 || gap_cnt !== 7'd0 || bit_cnt !== 7'd0) begin
      failures++;
      $display("FAIL restart: got state=%0d gap=%0d bit=%0d expected 0 0 0", state, gap_cnt, bit_cnt);
    end
    tick();
    checks++;
    if (gap_cnt !== 7'd1) begin failures++; $display("FAIL restart_gap: got %0d expected 1", gap_cnt); end
  endtask
`endif

  // Reset at edge 110, inside the frame-1 payload.
  // Expect an immediate abort, then an identical replay.
  task automatic test_mid_frame_reset();
    test_reset();
    while (edge_n < 109) tick();
    checks++;
    if (state !== 3'd1 || mdio_bus.mdio_t !== 1'b0) begin
      failures++;
      $display("FAIL pre_abort: got state=%0d t=%b expected 1 0", state, mdio_bus.mdio_t);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (state !== 3'd0 || gap_cnt !== 7'd0 || bit_cnt !== 7'd0) begin
      failures++;
      $display("FAIL abort_state: got state=%0d gap=%0d bit=%0d expected 0 0 0", state, gap_cnt, bit_cnt);
    end
    checks++;
    if (mdio_bus.mdio_t !== 1'b1 || mdio_bus.mdio_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_line: got t=%b o=%b expected 1 0", mdio_bus.mdio_t, mdio_bus.mdio_o);
    end
    reset  = 1'b0;
    edge_n = 0;
    test_gap1();
    test_preamble();
    test_frame1();
  endtask

  initial begin
    reset = 1'b1;
`ifdef MDIO_RESTART_EN
    restart = 1'b0;
`endif
    test_reset();
    test_gap1();
    test_preamble();
    test_frame1();
    test_full_sequence();
`ifdef MDIO_RESTART_EN
    test_restart();
`endif
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phy_mdio_ifc.md
Name: phy_mdio_ifc

Overview:
- Autonomous MDIO management-frame sequencer that configures an Ethernet PHY after reset.
- Drives the MDIO data/tri-state pair through three fixed Clause-22 write frames, each preceded by an idle gap, then parks in DONE with the line released.
- Sits between the Ethernet MAC top level and the MDIO pad buffer. The pad is driven with mdio_o when mdio_t=0 and released (high-Z) when mdio_t=1.
- MDC generation is outside this block; clk is the MDC-rate bit clock.

Parameters:
- GAP_CYCLES, 64: final gap-counter value; each gap state lasts GAP_CYCLES+1 cycles.
- CMD1, 32'h008C410A: frame 1 payload (start, op, phyad, regad, TA, data), sent LSB first.
- CMD2, 32'h0000650A: frame 2 payload, sent LSB first.
- CMD3, 32'h00CC410A: frame 3 payload, sent LSB first.

Ports:
- clk  input  1  bit clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- mdio_o  output  1  serial MDIO data to pad, registered.
- mdio_t  output  1  tri-state enable (1 = released/input, 0 = driving), registered.
- state  output  3  FSM state for debug. Encoding: GAP1=0, COMMAND1=1, GAP2=2, COMMAND2=3, GAP3=4, COMMAND3=5, DONE=6.
- gap_cnt  output  7  gap counter for debug.
- bit_cnt  output  7  bit counter for debug.
- done  output  1  high while state==DONE.

Behaviour:
- Reset (synchronous, active-high, sampled on the rising edge of clk): state=GAP1, gap_cnt=0, bit_cnt=0, mdio_o=0, mdio_t=1.
  - Reset asserted mid-frame aborts the frame immediately on that edge and restarts the full sequence from GAP1.
- GAPn (n=1,2,3), every cycle:
  - mdio_o<=0, mdio_t<=1.
  - If gap_cnt<GAP_CYCLES: gap_cnt++.
  - Else: gap_cnt<=0, bit_cnt<=0, state<=COMMANDn.
- COMMANDn, using bit_cnt value b:
  - b<32 (preamble): mdio_t<=0, mdio_o<=1, bit_cnt++.
  - 32<=b<64: mdio_t<=0, mdio_o<=CMDn[b-32], bit_cnt++. Payload bit 0 goes first.
  - b==64: mdio_t<=1, mdio_o<=0, bit_cnt<=0, then state<=GAP(n+1), or DONE after COMMAND3.
- DONE: mdio_t<=1, mdio_o<=0. State holds indefinitely; counters are held at 0.
- Timing:
  - Outputs are registered, so each value appears one cycle after the state/counter value that produced it.
  - Each gap lasts 65 cycles; each command lasts 65 cycles (32 preamble + 32 payload + 1 release).
  - Full sequence is 390 cycles from reset release to DONE.
- Counter widths: 7 bits; the maximum value reached is 64, so counters never wrap.
- mdio_t is never 0 outside COMMAND states.
- mdio_o is 0 whenever mdio_t=1.

Optional Feature:
- Macro: MDIO_RESTART_EN.
- Defined: adds input port restart (1 bit).
  - When state==DONE and restart=1, the next edge sets state=GAP1 with gap_cnt=0 and bit_cnt=0, replaying the full sequence.
  - restart is ignored in all other states.
- Undefined: port absent; DONE is terminal until reset.

Test Plan:
- Reset behaviour: hold reset=1 for 2 cycles.
  - Required: state=0, gap_cnt=0, bit_cnt=0, mdio_o=0, mdio_t=1.
- GAP1 timing: release reset and count edges.
  - Required: gap_cnt reads 1..64 after edges 1..64; state=COMMAND1 and gap_cnt=0 after edge 65.
  - Required: mdio_t=1 throughout.
- Preamble: after edge 66, mdio_t=0 and mdio_o=1, and both hold through edge 97 (32 ones).
  - Required: bit_cnt=32 after edge 97.
- Frame 1 payload: capture mdio_o after edges 98..129.
  - Required: serial bits equal 0x008C410A LSB first (0,1,0,1,0,0,0,0,1,0,...).
  - Required: after edge 130, mdio_t=1, mdio_o=0, state=GAP2.
- Full sequence: run 400 cycles.
  - Required: COMMAND2 payload 0x0000650A and COMMAND3 payload 0x00CC410A are serialized LSB first.
  - Required: state=DONE and done=1 after edge 390, with mdio_t=1 thereafter.
- Mid-frame reset: assert reset at edge 110 (inside the COMMAND1 payload).
  - Required: after that edge, state=GAP1, counters=0, mdio_t=1.
  - Required: the sequence then replays with identical timing.
